// File: rtl/stack_memory.sv
// LIFO operand stack: push/pop/replace-top with a registered top-of-stack,
// an occupancy count and sticky overflow/underflow flags.
module stack_memory #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clr,
  input  logic [WIDTH-1:0] memIn,
  output logic [WIDTH-1:0] memOut,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [CW-1:0]    count_d;
  logic [WIDTH-1:0] mem_out_d;
  logic             overflow_d;
  logic             underflow_d;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;

  // Occupancy decodes straight off the registered count.
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // Next-state selection: clr > push&pop > push > pop > idle.
  always_comb begin
    count_d     = count;
    mem_out_d   = memOut;
    overflow_d  = overflow;
    underflow_d = underflow;
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_data     = memIn;
    if (clr) begin
      count_d     = '0;
      mem_out_d   = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else if (push && pop && !empty) begin
      // Replace top in place; legal even when full.
      wr_en     = 1'b1;
      wr_addr   = AW'(count - CW'(1));
      mem_out_d = memIn;
    end else if (push) begin
      // Also covers push&pop on an empty stack (plain push, no underflow).
      if (!full) begin
        wr_en     = 1'b1;
        wr_addr   = AW'(count);
        count_d   = count + CW'(1);
        mem_out_d = memIn;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (pop) begin
      if (!empty) begin
        count_d   = count - CW'(1);
        mem_out_d = (count >= CW'(2)) ? mem[AW'(count - CW'(2))] : '0;
      end else begin
        underflow_d = 1'b1;
      end
    end
  end

  // Control/status registers; reset overrides any strobe in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count     <= '0;
      memOut    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= count_d;
      memOut    <= mem_out_d;
      overflow  <= overflow_d;
      underflow <= underflow_d;
    end
  end

  // Storage array is not reset; entries at or above count are never read.
  always_ff @(posedge clk) begin
    if (rst && wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_stack_memory.sv
// Self-checking bench for stack_memory (WIDTH=32, DEPTH=4) against a
// queue-based LIFO model.
module tb_stack_memory;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst;
  logic             push;
  logic             pop;
  logic             clr;
  logic [WIDTH-1:0] memIn;
  logic [WIDTH-1:0] memOut;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  int errors;
  int checks;

  // Reference model: the queue back is the top of stack.
  logic [WIDTH-1:0] q[$];
  bit               m_ovf;
  bit               m_unf;

  stack_memory #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .clr       (clr),
    .memIn     (memIn),
    .memOut    (memOut),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] m_top();
    return (q.size() > 0) ? q[$] : '0;
  endfunction

  // Drive one operation for one cycle and advance the model.
  task automatic do_op(input bit p, input bit o, input bit c, input logic [WIDTH-1:0] d);
    push  = p;
    pop   = o;
    clr   = c;
    memIn = d;
    @(posedge clk);
    #1;
    push  = 1'b0;
    pop   = 1'b0;
    clr   = 1'b0;
    if (c) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (p && o && q.size() > 0) begin
      q[$] = d;
    end else if (p) begin
      if (q.size() < DEPTH) q.push_back(d);
      else m_ovf = 1'b1;
    end else if (o) begin
      if (q.size() > 0) void'(q.pop_back());
      else m_unf = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    checks++;
    if (memOut !== 32'h0) begin errors++; $display("FAIL reset_memout: got %h want 0", memOut); end
    checks++;
    if (count !== CW'(0)) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      errors++; $display("FAIL reset_empty_full: got empty=%b full=%b want 1 0", empty, full);
    end
    checks++;
    if (overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got ovf=%b unf=%b want 0 0", overflow, underflow);
    end
  endtask

  task automatic test_push();
    logic [WIDTH-1:0] vals [3];
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
    for (int i = 0; i < 3; i++) begin
      do_op(1'b1, 1'b0, 1'b0, vals[i]);
      checks++;
      if (memOut !== vals[i]) begin errors++; $display("FAIL push_memout[%0d]: got %h want %h", i, memOut, vals[i]); end
      checks++;
      if (count !== CW'(i + 1)) begin errors++; $display("FAIL push_count[%0d]: got %0d want %0d", i, count, i + 1); end
    end
    checks++;
    if (empty !== 1'b0) begin errors++; $display("FAIL push_empty: got %b want 0", empty); end
  endtask

  task automatic test_pop();
    do_op(1'b0, 1'b1, 1'b0, '0);
    checks++;
    if (memOut !== 32'h22 || count !== CW'(2)) begin
      errors++; $display("FAIL pop1: got memOut=%h count=%0d want 22 2", memOut, count);
    end
    do_op(1'b0, 1'b0, 1'b0, '0);
    do_op(1'b0, 1'b1, 1'b0, '0);
    checks++;
    if (memOut !== 32'h11 || count !== CW'(1)) begin
      errors++; $display("FAIL pop2: got memOut=%h count=%0d want 11 1", memOut, count);
    end
  endtask

  task automatic test_overflow();
    do_op(1'b1, 1'b0, 1'b0, 32'h22);
    do_op(1'b1, 1'b0, 1'b0, 32'h33);
    do_op(1'b1, 1'b0, 1'b0, 32'h44);
    checks++;
    if (full !== 1'b1 || count !== CW'(4) || overflow !== 1'b0) begin
      errors++; $display("FAIL fill: got full=%b count=%0d ovf=%b want 1 4 0", full, count, overflow);
    end
    do_op(1'b1, 1'b0, 1'b0, 32'h99);
    checks++;
    if (overflow !== 1'b1 || count !== CW'(4) || memOut !== 32'h44) begin
      errors++; $display("FAIL overflow: got ovf=%b count=%0d memOut=%h want 1 4 44", overflow, count, memOut);
    end
    do_op(1'b1, 1'b1, 1'b0, 32'h77);
    checks++;
    if (memOut !== 32'h77 || count !== CW'(4) || full !== 1'b1) begin
      errors++; $display("FAIL replace_full: got memOut=%h count=%0d full=%b want 77 4 1", memOut, count, full);
    end
    // Pop after replace must expose the entry below, not the replaced one.
    do_op(1'b0, 1'b1, 1'b0, '0);
    checks++;
    if (memOut !== 32'h33 || count !== CW'(3)) begin
      errors++; $display("FAIL pop_after_replace: got memOut=%h count=%0d want 33 3", memOut, count);
    end
  endtask

  task automatic test_underflow_clr();
    do_op(1'b0, 1'b0, 1'b1, '0);
    checks++;
    if (count !== CW'(0) || memOut !== 32'h0 || overflow !== 1'b0) begin
      errors++; $display("FAIL clr: got count=%0d memOut=%h ovf=%b want 0 0 0", count, memOut, overflow);
    end
    do_op(1'b0, 1'b1, 1'b0, '0);
    checks++;
    if (underflow !== 1'b1 || count !== CW'(0) || memOut !== 32'h0) begin
      errors++; $display("FAIL underflow: got unf=%b count=%0d memOut=%h want 1 0 0", underflow, count, memOut);
    end
    // clr outranks a simultaneous push.
    do_op(1'b1, 1'b0, 1'b1, 32'hDEAD);
    checks++;
    if (underflow !== 1'b0 || count !== CW'(0) || memOut !== 32'h0) begin
      errors++; $display("FAIL clr_push: got unf=%b count=%0d memOut=%h want 0 0 0", underflow, count, memOut);
    end
  endtask

  task automatic test_reset_priority();
    do_op(1'b1, 1'b0, 1'b0, 32'h3);
    push  = 1'b1;
    memIn = 32'h5;
    rst   = 1'b0;
    @(posedge clk);
    #1;
    rst  = 1'b1;
    push = 1'b0;
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    checks++;
    if (count !== CW'(0) || memOut !== 32'h0) begin
      errors++; $display("FAIL reset_push: got count=%0d memOut=%h want 0 0", count, memOut);
    end
    do_op(1'b1, 1'b1, 1'b0, 32'hA);
    checks++;
    if (count !== CW'(1) || memOut !== 32'hA || underflow !== 1'b0) begin
      errors++; $display("FAIL pushpop_empty: got count=%0d memOut=%h unf=%b want 1 a 0", count, memOut, underflow);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      int unsigned r;
      bit p, o, c;
      r = $urandom_range(0, 99);
      c = (r < 4);
      p = (r >= 4 && r < 52) || (r >= 85);
      o = (r >= 52);
      do_op(p, o, c, $urandom);
      checks++;
      if (memOut !== m_top() || count !== CW'(q.size()) ||
          empty !== (q.size() == 0) || full !== (q.size() == DEPTH) ||
          overflow !== m_ovf || underflow !== m_unf) begin
        errors++;
        $display("FAIL random[%0d]: got memOut=%h count=%0d e=%b f=%b ovf=%b unf=%b want %h %0d %b %b %b %b",
                 i, memOut, count, empty, full, overflow, underflow,
                 m_top(), q.size(), q.size() == 0, q.size() == DEPTH, m_ovf, m_unf);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b0;
    push   = 1'b0;
    pop    = 1'b0;
    clr    = 1'b0;
    memIn  = '0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    test_reset();
    test_push();
    test_pop();
    test_overflow();
    test_underflow_clr();
    test_reset_priority();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
